// File: rtl/pipe_pkg.sv
// Shared types and constants for the M/W pipeline stages.
// The memory-request FSM and the stage registers both import these.
package pipe_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_write;
        logic pc_src;
    } ctrl_m_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic pc_src;
    } ctrl_w_t;

    localparam ctrl_m_t    BUBBLE_CTRL     = '0;
    localparam ctrl_w_t    BUBBLE_W        = '0;
    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return (lsb & WORD_ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/mem_req_ctrl.sv
// Data-memory handshake FSM: issues dmem_req, counts wait cycles, raises
// the M-stage stall and aborts with a bus error when the ack never comes.
module mem_req_ctrl
    import pipe_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic memop,
    input  logic misalign,
    input  logic dmem_ack,
    output logic dmem_req,
    output logic stall,
    output logic abort,
    output logic bus_error
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    mem_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             access;

    assign access = memop & ~misalign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dmem_req = 1'b0;
        abort    = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    dmem_req = 1'b1;
                    // zero-wait completion never leaves IDLE
                    if (!dmem_ack) begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            WAIT: begin
                dmem_req = 1'b1;
                if (dmem_ack) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(MAX_WAIT)) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // The abort cycle releases the stall so the dead op drains into W.
    assign stall     = access & ~dmem_ack & ~abort;
    assign bus_error = abort | (memop & misalign);

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: E->M register, data-memory interface via mem_req_ctrl,
// and M->W register carrying load data and ALU results to write-back.
module mem_stage
    import pipe_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              RegWriteE,
    input  logic              MemtoRegE,
    input  logic              MemWriteE,
    input  logic              PCSrcE,
    input  logic [3:0]        RdE,
    input  logic [DATA_W-1:0] ALUResultE,
    input  logic [DATA_W-1:0] WriteDataE,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              stallM,
    output logic              RegWriteM,
    output logic [3:0]        RdM,
    output logic [DATA_W-1:0] ALUResultM,
    output logic              RegWriteW,
    output logic              MemtoRegW,
    output logic              PCSrcW,
    output logic [3:0]        RdW,
    output logic [DATA_W-1:0] ReadDataW,
    output logic [DATA_W-1:0] ALUOutW,
    output logic              bus_error
);

    ctrl_m_t           ctrl_m_q, ctrl_m_d;
    logic [3:0]        rd_m_q, rd_m_d;
    logic [DATA_W-1:0] alu_m_q, alu_m_d;
    logic [DATA_W-1:0] wdata_m_q, wdata_m_d;

    ctrl_w_t           ctrl_w_q, ctrl_w_d;
    logic [3:0]        rd_w_q, rd_w_d;
    logic [DATA_W-1:0] rdata_w_q, rdata_w_d;
    logic [DATA_W-1:0] alu_w_q, alu_w_d;

    logic memop_m;
    logic misalign;
    logic abort;
    logic load_done;

    assign memop_m   = ctrl_m_q.mem_to_reg | ctrl_m_q.mem_write;
    assign misalign  = memop_m & is_misaligned(alu_m_q[1:0]);
    assign load_done = dmem_req & dmem_ack & ctrl_m_q.mem_to_reg;

    mem_req_ctrl #(
        .MAX_WAIT (MAX_WAIT)
    ) u_req_ctrl (
        .clk       (clk),
        .rst_n     (reset),
        .memop     (memop_m),
        .misalign  (misalign),
        .dmem_ack  (dmem_ack),
        .dmem_req  (dmem_req),
        .stall     (stallM),
        .abort     (abort),
        .bus_error (bus_error)
    );

    // M register: a stalled M op is older than any branch, so flush waits.
    always_comb begin
        ctrl_m_d  = ctrl_m_q;
        rd_m_d    = rd_m_q;
        alu_m_d   = alu_m_q;
        wdata_m_d = wdata_m_q;
        if (!stallM) begin
            if (flush) begin
                ctrl_m_d  = BUBBLE_CTRL;
                rd_m_d    = '0;
                alu_m_d   = '0;
                wdata_m_d = '0;
            end else begin
                ctrl_m_d  = '{reg_write:  RegWriteE,
                              mem_to_reg: MemtoRegE,
                              mem_write:  MemWriteE,
                              pc_src:     PCSrcE};
                rd_m_d    = RdE;
                alu_m_d   = ALUResultE;
                wdata_m_d = WriteDataE;
            end
        end
    end

    // W register: bubbles during a stall keep the register file from a double write.
    always_comb begin
        ctrl_w_d  = BUBBLE_W;
        rd_w_d    = '0;
        rdata_w_d = '0;
        alu_w_d   = '0;
        if (!stallM) begin
            ctrl_w_d.reg_write  = ctrl_m_q.reg_write & ~misalign & ~abort;
            ctrl_w_d.mem_to_reg = ctrl_m_q.mem_to_reg & ~misalign;
            ctrl_w_d.pc_src     = ctrl_m_q.pc_src;
            rd_w_d              = rd_m_q;
            alu_w_d             = alu_m_q;
            rdata_w_d           = load_done ? dmem_rdata : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_m_q  <= BUBBLE_CTRL;
            rd_m_q    <= '0;
            alu_m_q   <= '0;
            wdata_m_q <= '0;
            ctrl_w_q  <= BUBBLE_W;
            rd_w_q    <= '0;
            rdata_w_q <= '0;
            alu_w_q   <= '0;
        end else begin
            ctrl_m_q  <= ctrl_m_d;
            rd_m_q    <= rd_m_d;
            alu_m_q   <= alu_m_d;
            wdata_m_q <= wdata_m_d;
            ctrl_w_q  <= ctrl_w_d;
            rd_w_q    <= rd_w_d;
            rdata_w_q <= rdata_w_d;
            alu_w_q   <= alu_w_d;
        end
    end

    assign dmem_we    = ctrl_m_q.mem_write;
    assign dmem_addr  = {alu_m_q[DATA_W-1:2], 2'b00};
    assign dmem_wdata = wdata_m_q;

    assign RegWriteM  = ctrl_m_q.reg_write;
    assign RdM        = rd_m_q;
    assign ALUResultM = alu_m_q;

    assign RegWriteW  = ctrl_w_q.reg_write;
    assign MemtoRegW  = ctrl_w_q.mem_to_reg;
    assign PCSrcW     = ctrl_w_q.pc_src;
    assign RdW        = rd_w_q;
    assign ReadDataW  = rdata_w_q;
    assign ALUOutW    = alu_w_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: an instruction-level model predicts stalls,
// bus errors, memory requests and W contents; a responder and a W monitor check them.
module tb_mem_stage;

    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 15;
    localparam int N_RAND   = 60;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              flush = 1'b0;
    logic              RegWriteE = 1'b0, MemtoRegE = 1'b0, MemWriteE = 1'b0, PCSrcE = 1'b0;
    logic [3:0]        RdE = '0;
    logic [DATA_W-1:0] ALUResultE = '0, WriteDataE = '0;
    logic              dmem_req, dmem_we;
    logic [DATA_W-1:0] dmem_addr, dmem_wdata;
    logic              dmem_ack = 1'b0;
    logic [DATA_W-1:0] dmem_rdata = '0;
    logic              stallM, RegWriteM;
    logic [3:0]        RdM;
    logic [DATA_W-1:0] ALUResultM;
    logic              RegWriteW, MemtoRegW, PCSrcW;
    logic [3:0]        RdW;
    logic [DATA_W-1:0] ReadDataW, ALUOutW;
    logic              bus_error;
    logic              any_out;

    mem_stage #(.MAX_WAIT(MAX_WAIT), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE), .PCSrcE(PCSrcE),
        .RdE(RdE), .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stallM(stallM), .RegWriteM(RegWriteM), .RdM(RdM), .ALUResultM(ALUResultM),
        .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .PCSrcW(PCSrcW), .RdW(RdW),
        .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    assign any_out = |{dmem_req, dmem_we, dmem_addr, dmem_wdata, stallM, RegWriteM, RdM,
                       ALUResultM, RegWriteW, MemtoRegW, PCSrcW, RdW, ReadDataW, ALUOutW, bus_error};

    // lat: ack arrives that many cycles after the op reaches M; -1 = never
    typedef struct {
        bit flush, rw, mtr, mw, pc;
        bit [3:0] rd;
        bit [31:0] alu, wd, rdata;
        int lat;
    } instr_t;
    typedef struct {
        bit bubble, rw, mtr, pc;
        bit [3:0] rd;
        bit [31:0] alu, rdata;
    } wexp_t;
    typedef struct {
        bit [31:0] addr, wdata, rdata;
        bit we;
        int lat;
    } req_t;

    int     checks = 0;
    int     fails  = 0;
    bit     resp_en = 1'b1;
    instr_t stim[$];
    wexp_t  wq[$];
    req_t   rq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic instr_t mk(bit fl, bit rw, bit mtr, bit mw, bit pc, bit [3:0] rd,
                                  bit [31:0] alu, bit [31:0] wd, int lat, bit [31:0] rdata);
        instr_t i;
        i.flush = fl; i.rw = rw; i.mtr = mtr; i.mw = mw; i.pc = pc; i.rd = rd;
        i.alu = alu; i.wd = wd; i.lat = lat; i.rdata = rdata;
        return i;
    endfunction

    function automatic bit is_mem(instr_t i); return i.mtr | i.mw; endfunction
    function automatic bit is_mis(instr_t i); return is_mem(i) && (i.alu % 4 != 0); endfunction
    function automatic bit is_tmo(instr_t i); return is_mem(i) && !is_mis(i) && i.lat < 0; endfunction

    function automatic int stalls(instr_t i);
        if (!is_mem(i) || is_mis(i)) return 0;
        return is_tmo(i) ? MAX_WAIT : i.lat;
    endfunction

    function automatic wexp_t w_of(instr_t i);
        wexp_t w;
        w.bubble = 1'b0;
        w.rw     = i.rw && !is_mis(i) && !is_tmo(i);
        w.mtr    = i.mtr && !is_mis(i);
        w.pc     = i.pc;
        w.rd     = i.rd;
        w.alu    = i.alu;
        w.rdata  = (i.mtr && !is_mis(i) && !is_tmo(i)) ? i.rdata : 32'h0;
        return w;
    endfunction

    function automatic instr_t rnd_instr();
        instr_t i;
        int kind = $urandom_range(0, 9);
        i = mk(kind == 9, 1'($urandom), kind >= 3 && kind < 6, kind >= 6 && kind < 9, 1'($urandom),
               4'($urandom), $urandom, $urandom, ($urandom_range(0, 19) == 0) ? -1 : $urandom_range(0, 3),
               $urandom);
        if (is_mem(i) && $urandom_range(0, 7) != 0) i.alu = i.alu & 32'hFFFF_FFFC;
        return i;
    endfunction

    task automatic drive(input instr_t i, input bit fl);
        flush = fl; RegWriteE = i.rw; MemtoRegE = i.mtr; MemWriteE = i.mw; PCSrcE = i.pc;
        RdE = i.rd; ALUResultE = i.alu; WriteDataE = i.wd;
    endtask

    // Memory responder: acks each request after its planned latency and checks
    // that address/data/we match the op and stay stable while the request is held.
    initial begin
        req_t cr;
        bit   active = 1'b0;
        int   waited = 0;
        forever begin
            @(posedge clk); #2;
            dmem_ack   = 1'b0;
            dmem_rdata = $urandom;
            if (resp_en) begin
                if (dmem_req) begin
                    if (!active && rq.size() == 0) begin
                        check("unexpected_req", 32'(dmem_req), 32'd0);
                    end else begin
                        if (!active) begin
                            cr = rq.pop_front();
                            active = 1'b1;
                            waited = 0;
                        end
                        check("req_addr", dmem_addr, cr.addr);
                        check("req_we", 32'(dmem_we), 32'(cr.we));
                        check("req_wdata", dmem_wdata, cr.wdata);
                        if (cr.lat >= 0 && waited == cr.lat) begin
                            dmem_ack   = 1'b1;
                            dmem_rdata = cr.rdata;
                        end
                        if (dmem_ack || (cr.lat < 0 && waited == MAX_WAIT)) active = 1'b0;
                        waited++;
                    end
                end else if (active) begin
                    check("req_dropped", 32'(dmem_req), 32'd1);
                    active = 1'b0;
                end
            end
        end
    end

    // W monitor: one expected entry per clock edge, bubble or real op.
    initial begin
        wexp_t e;
        forever begin
            @(posedge clk); #3;
            if (wq.size() > 0) begin
                e = wq.pop_front();
                check("W_regwrite", 32'(RegWriteW), 32'(e.rw));
                check("W_pcsrc", 32'(PCSrcW), 32'(e.pc));
                if (!e.bubble) begin
                    check("W_memtoreg", 32'(MemtoRegW), 32'(e.mtr));
                    check("W_rd", 32'(RdW), 32'(e.rd));
                    check("W_aluout", ALUOutW, e.alu);
                    check("W_readdata", ReadDataW, e.rdata);
                end
            end
        end
    end

    // Driver and cycle-level model of the M stage.
    initial begin
        instr_t nop, cur, m_i;
        wexp_t  bub;
        req_t   r;
        int     m_left, idx;
        bit     exp_stall, exp_err;

        nop = mk(0, 0, 0, 0, 0, 4'd0, 32'h0, 32'h0, 0, 32'h0);
        bub = w_of(nop);
        bub.bubble = 1'b1;
        stim.push_back(mk(0, 1, 1, 0, 0, 4'd5, 32'h100, 32'h0, 0, 32'hDEADBEEF));
        stim.push_back(mk(0, 0, 0, 1, 0, 4'd1, 32'h200, 32'h1234, 3, 32'h0));
        stim.push_back(mk(0, 1, 1, 0, 1, 4'd7, 32'h300, 32'h0, -1, 32'h5555));
        stim.push_back(mk(0, 1, 1, 0, 0, 4'd2, 32'h104, 32'h0, 1, 32'hCAFE0001));
        stim.push_back(mk(0, 1, 1, 0, 0, 4'd9, 32'h102, 32'h0, 0, 32'h1111));
        stim.push_back(mk(1, 1, 1, 0, 1, 4'd4, 32'h400, 32'h0, 2, 32'h2222));
        stim.push_back(mk(0, 1, 0, 0, 1, 4'd6, 32'h1357_9BDF, 32'h0, 0, 32'h0));
        stim.push_back(mk(0, 1, 1, 0, 0, 4'd8, 32'h500, 32'h0, 0, 32'h0BAD_F00D));
        stim.push_back(mk(0, 1, 1, 0, 0, 4'd3, 32'h504, 32'h0, 0, 32'h600D_F00D));
        for (int k = 0; k < N_RAND; k++) stim.push_back(rnd_instr());
        stim.push_back(nop);
        stim.push_back(nop);

        drive(nop, 1'b0);
        #12;
        check("rst_any_out", 32'(any_out), 32'd0);
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_stall", 32'(stallM), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        m_i = nop;
        m_left = 0;
        idx = 0;
        while (idx < stim.size()) begin
            cur = stim[idx];
            @(posedge clk); #1;
            // while M is known to be stalled, a flush must be ignored
            drive(cur, (m_left > 0) ? 1'($urandom) : cur.flush);
            @(negedge clk);
            exp_stall = (m_left > 0);
            exp_err   = !exp_stall && (is_mis(m_i) || is_tmo(m_i));
            check("stallM", 32'(stallM), 32'(exp_stall));
            check("bus_error", 32'(bus_error), 32'(exp_err));
            check("RegWriteM", 32'(RegWriteM), 32'(m_i.rw));
            check("RdM", 32'(RdM), 32'(m_i.rd));
            check("ALUResultM", ALUResultM, m_i.alu);
            if (exp_stall) begin
                wq.push_back(bub);
                m_left--;
            end else begin
                wq.push_back(w_of(m_i));
                m_i = cur.flush ? nop : cur;
                if (is_mem(m_i) && !is_mis(m_i)) begin
                    r.addr = m_i.alu; r.we = m_i.mw; r.wdata = m_i.wd;
                    r.rdata = m_i.rdata; r.lat = m_i.lat;
                    rq.push_back(r);
                end
                m_left = stalls(m_i);
                idx++;
            end
        end

        for (int k = 0; k < 20 && (wq.size() > 0 || rq.size() > 0); k++) @(posedge clk);
        check("drain_w_queue", 32'(wq.size()), 32'd0);
        check("drain_req_queue", 32'(rq.size()), 32'd0);

        // async reset in the middle of a WAIT with cnt = 7
        @(negedge clk);
        resp_en = 1'b0;
        @(posedge clk); #1;
        drive(mk(0, 1, 1, 0, 0, 4'd3, 32'h300, 32'h0, -1, 32'h0), 1'b0);
        @(posedge clk); #1;
        drive(nop, 1'b0);
        repeat (7) @(posedge clk);
        #2;
        check("pre_rst_req", 32'(dmem_req), 32'd1);
        check("pre_rst_stall", 32'(stallM), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("arst_req", 32'(dmem_req), 32'd0);
        check("arst_stall", 32'(stallM), 32'd0);
        check("arst_any_out", 32'(any_out), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("post_rst_any_out", 32'(any_out), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
